// File: rtl/qspi_sram.sv
// Quad-SPI (SQI) serial SRAM model: permanent quad mode, byte-sequential READ (0x03)
// and WRITE (0x02) with a 24-bit address and wrapping auto-increment.
module qspi_sram #(
    parameter int ADDR_BITS  = 16,
    parameter int DUMMY_CLKS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic CSn,
    inout  wire  IO0,
    inout  wire  IO1,
    inout  wire  IO2,
    inout  wire  IO3
);
    localparam logic [2:0] ST_CMD   = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_DUMMY = 3'd2;
    localparam logic [2:0] ST_RD    = 3'd3;
    localparam logic [2:0] ST_WR    = 3'd4;
    localparam logic [2:0] ST_IGN   = 3'd5;
    localparam int MEM_DEPTH = 2 ** ADDR_BITS;

    logic [7:0]           mem [0:MEM_DEPTH-1];
    logic [7:0]           rd_data_reg;
    logic [2:0]           state_reg;
    logic [7:0]           cnt_reg;
    logic [3:0]           cmd_reg;
    logic                 is_read_reg;
    logic [ADDR_BITS-1:0] addr_reg;
    logic [3:0]           half_reg;
    logic                 lo_reg;
    logic                 io_oe_reg;
    logic [3:0]           io_dout_reg;

    logic                 abort;
    logic                 io_oe;
    logic [3:0]           io_in;
    logic [7:0]           cmd_full;
    logic [ADDR_BITS-1:0] addr_shift;
    logic                 addr_done;
    logic                 enter_rd;
    logic                 fetch_en;
    logic [ADDR_BITS-1:0] fetch_addr;
    logic                 mem_we;

    // CSn high behaves exactly like reset for the bus logic; memory is untouched.
    assign abort = rst | CSn;
    assign io_oe = io_oe_reg & ~abort;

    assign IO0 = io_oe ? io_dout_reg[0] : 1'bz;
    assign IO1 = io_oe ? io_dout_reg[1] : 1'bz;
    assign IO2 = io_oe ? io_dout_reg[2] : 1'bz;
    assign IO3 = io_oe ? io_dout_reg[3] : 1'bz;
    assign io_in = {IO3, IO2, IO1, IO0};

    assign cmd_full   = {cmd_reg, io_in};
    assign addr_shift = {addr_reg[ADDR_BITS-5:0], io_in};
    assign addr_done  = (state_reg == ST_ADDR) && (cnt_reg == 8'd5);
    // The first byte is fetched on the last dummy edge (or last address edge with no dummies).
    assign enter_rd   = is_read_reg &&
                        (((DUMMY_CLKS == 0) && addr_done) ||
                         ((state_reg == ST_DUMMY) && (cnt_reg == 8'(DUMMY_CLKS - 1))));
    assign fetch_en   = enter_rd || ((state_reg == ST_RD) && lo_reg);
    assign fetch_addr = (state_reg == ST_ADDR) ? addr_shift : addr_reg;
    assign mem_we     = (state_reg == ST_WR) && lo_reg && !abort;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[addr_reg] <= {half_reg, io_in};
        if (fetch_en)
            rd_data_reg <= mem[fetch_addr];
    end

    always_ff @(posedge clk or posedge abort) begin
        if (abort) begin
            state_reg   <= ST_CMD;
            cnt_reg     <= 8'd0;
            cmd_reg     <= 4'h0;
            is_read_reg <= 1'b0;
            addr_reg    <= '0;
            half_reg    <= 4'h0;
            lo_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_CMD: begin
                    cmd_reg <= io_in;
                    if (cnt_reg == 8'd0) begin
                        cnt_reg <= 8'd1;
                    end else begin
                        cnt_reg <= 8'd0;
                        if (cmd_full == 8'h02) begin
                            state_reg   <= ST_ADDR;
                            is_read_reg <= 1'b0;
                        end else if (cmd_full == 8'h03) begin
                            state_reg   <= ST_ADDR;
                            is_read_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_IGN;
                        end
                    end
                end
                ST_ADDR: begin
                    addr_reg <= addr_shift;
                    cnt_reg  <= cnt_reg + 8'd1;
                    if (addr_done) begin
                        cnt_reg <= 8'd0;
                        lo_reg  <= 1'b0;
                        if (!is_read_reg)
                            state_reg <= ST_WR;
                        else if (enter_rd)
                            state_reg <= ST_RD;
                        else
                            state_reg <= ST_DUMMY;
                    end
                end
                ST_DUMMY: begin
                    cnt_reg <= cnt_reg + 8'd1;
                    if (enter_rd) begin
                        state_reg <= ST_RD;
                        lo_reg    <= 1'b0;
                    end
                end
                ST_RD: begin
                    // Advance the address while the low nibble goes out; the next edge refetches.
                    lo_reg <= ~lo_reg;
                    if (!lo_reg)
                        addr_reg <= addr_reg + 1'b1;
                end
                ST_WR: begin
                    if (!lo_reg) begin
                        half_reg <= io_in;
                        lo_reg   <= 1'b1;
                    end else begin
                        lo_reg   <= 1'b0;
                        addr_reg <= addr_reg + 1'b1;
                    end
                end
                default: state_reg <= state_reg;
            endcase
        end
    end

    // Read data is launched on the falling edge so the master can sample on the rising edge.
    always_ff @(negedge clk or posedge abort) begin
        if (abort) begin
            io_oe_reg   <= 1'b0;
            io_dout_reg <= 4'h0;
        end else if (state_reg == ST_RD) begin
            io_oe_reg   <= 1'b1;
            io_dout_reg <= lo_reg ? rd_data_reg[3:0] : rd_data_reg[7:4];
        end else begin
            io_oe_reg <= 1'b0;
        end
    end
endmodule

// File: tb/tb_qspi_sram.sv
// Scoreboard bench for qspi_sram: the master pushes one expected bus state per clock
// slot, a monitor pops and compares on every rising edge while CSn is low.
module tb_qspi_sram;
    localparam int DUMMY = 2;

    logic clk = 1'b0;
    logic rst;
    logic CSn;
    logic m_oe;
    logic [3:0] m_dout;
    wire IO0, IO1, IO2, IO3;

    typedef struct packed {
        logic       oe;
        logic [3:0] d;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    assign IO0 = m_oe ? m_dout[0] : 1'bz;
    assign IO1 = m_oe ? m_dout[1] : 1'bz;
    assign IO2 = m_oe ? m_dout[2] : 1'bz;
    assign IO3 = m_oe ? m_dout[3] : 1'bz;

    qspi_sram #(.ADDR_BITS(16), .DUMMY_CLKS(DUMMY)) dut (
        .clk(clk),
        .rst(rst),
        .CSn(CSn),
        .IO0(IO0),
        .IO1(IO1),
        .IO2(IO2),
        .IO3(IO3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end else begin
            $display("ok   %s: %h at %0t", name, act, $time);
        end
    endtask

    // Monitor: pops one expectation per rising edge of an open CS window.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!CSn && !rst) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 8'd1, 8'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_drive", {7'd0, dut.io_oe}, {7'd0, e.oe});
                    if (e.oe)
                        check("read_nibble", {4'h0, IO3, IO2, IO1, IO0}, {4'h0, e.d});
                end
            end else begin
                check("idle_highz", {7'd0, dut.io_oe}, 8'd0);
            end
        end
    end

    task automatic slot_drive(input logic [3:0] n);
        m_oe   = 1'b1;
        m_dout = n;
        exp_q.push_back('{oe: 1'b0, d: 4'h0});
        @(negedge clk);
    endtask

    task automatic slot_read(input logic oe, input logic [3:0] d);
        m_oe = 1'b0;
        exp_q.push_back('{oe: oe, d: d});
        @(negedge clk);
    endtask

    task automatic cs_begin();
        @(negedge clk);
        CSn = 1'b0;
    endtask

    task automatic cs_end();
        CSn  = 1'b1;
        m_oe = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        slot_drive(b[7:4]);
        slot_drive(b[3:0]);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
        send_byte(cmd);
        for (int i = 5; i >= 0; i--)
            slot_drive(addr[i*4 +: 4]);
    endtask

    task automatic write_mem(input logic [23:0] addr, input logic [15:0] data, input int n);
        cs_begin();
        send_hdr(8'h02, addr);
        for (int k = 0; k < n; k++)
            send_byte(data[15 - 8*k -: 8]);
        cs_end();
    endtask

    task automatic read_hdr(input logic [23:0] addr);
        cs_begin();
        send_hdr(8'h03, addr);
        for (int k = 0; k < DUMMY; k++)
            slot_read(1'b0, 4'h0);
    endtask

    task automatic read_mem(input logic [23:0] addr, input logic [15:0] data, input int n);
        read_hdr(addr);
        for (int k = 0; k < n; k++) begin
            slot_read(1'b1, data[15 - 8*k -: 4]);
            slot_read(1'b1, data[11 - 8*k -: 4]);
        end
        cs_end();
    endtask

    initial begin
        rst    = 1'b1;
        CSn    = 1'b1;
        m_oe   = 1'b0;
        m_dout = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_highz", {7'd0, dut.io_oe}, 8'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write then read back two bytes
        write_mem(24'h001234, 16'hA53C, 2);
        read_mem(24'h001234, 16'hA53C, 2);

        // Wrap from 0xFFFF to 0x0000 on write and on streaming read
        write_mem(24'h00FFFF, 16'h1122, 2);
        read_mem(24'h00FFFF, 16'h1122, 2);
        read_mem(24'h000000, 16'h2200, 1);

        // Upper address bits are ignored
        write_mem(24'hAB0010, 16'h7700, 1);
        read_mem(24'h000010, 16'h7700, 1);

        // Half-byte write aborted by CSn leaves memory alone
        write_mem(24'h000020, 16'h5500, 1);
        cs_begin();
        send_hdr(8'h02, 24'h000020);
        slot_drive(4'hA);
        cs_end();
        read_mem(24'h000020, 16'h5500, 1);

        // Reset mid read-data phase releases IO at once
        read_hdr(24'h001234);
        slot_read(1'b1, 4'hA);
        slot_read(1'b1, 4'h5);
        #1;
        check("oe_before_rst", {7'd0, dut.io_oe}, 8'd1);
        rst = 1'b1;
        #1;
        check("oe_after_rst", {7'd0, dut.io_oe}, 8'd0);
        CSn  = 1'b1;
        m_oe = 1'b0;
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        read_mem(24'h001234, 16'hA53C, 2);

        // Illegal command: no drive for the whole window, no memory change
        cs_begin();
        send_hdr(8'h9F, 24'h000010);
        send_byte(8'h88);
        send_byte(8'h99);
        cs_end();
        read_mem(24'h000010, 16'h7700, 1);

        repeat (2) @(negedge clk);
        check("queue_drain", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
